// File: rtl/mem_responder.sv
// Word-addressed memory behind a request/response port with one outstanding read
// and a fixed read latency. Define MEM_RESP_RANGE_CHECK_EN for out-of-range checking.
module mem_responder #(
   parameter int width   = 32,
   parameter int depth   = 2048,
   parameter int latency = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [width-1:0] req_addr,
   input  logic [width-1:0] req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [width-1:0] resp_rdata,
   output logic             resp_err
);
   localparam int         AW     = $clog2(depth);
   localparam logic [3:0] LAT_M1 = 4'(latency - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic             ready_en;
   logic             resp_load;
   logic             accept, wr_en, rd_accept;
   logic [AW-1:0]    req_idx, idx_p0, rd_idx;
   logic             req_oor, err_p0, rd_oor;
   logic [width-1:0] mem [depth];

   assign req_idx = req_addr[AW-1:0];

`ifdef MEM_RESP_RANGE_CHECK_EN
   assign req_oor = (req_addr >> AW) != '0;
`else
   logic unused_addr_hi;
   assign req_oor        = 1'b0;
   assign unused_addr_hi = ^(req_addr >> AW);
`endif

   // ready_en holds req_ready low until the first edge after reset release
   assign req_ready  = (state == IDLE) && ready_en;
   assign resp_valid = (state == RESP);
   assign accept     = req_valid && req_ready;
   assign wr_en      = accept && req_write && !req_oor;
   assign rd_accept  = accept && !req_write;

   // A latency-1 read loads straight from the live request on its accept edge
   assign rd_idx = (state == IDLE) ? req_idx : idx_p0;
   assign rd_oor = (state == IDLE) ? req_oor : err_p0;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      resp_load = 1'b0;
      case (state)
         IDLE: begin
            if (rd_accept) begin
               if (latency == 1) begin
                  state_nxt = RESP;
                  resp_load = 1'b1;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = LAT_M1;
               end
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nxt = RESP;
               resp_load = 1'b1;
            end
         end
         RESP: begin
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: request capture
   always_ff @(posedge clk) begin
      if (wr_en) mem[req_idx] <= req_wdata;
   end

   always_ff @(posedge clk) begin
      if (rd_accept) begin
         idx_p0 <= req_idx;
         err_p0 <= req_oor;
      end
   end

   // Stage p1: control and response register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         ready_en   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         ready_en <= 1'b1;
         if (resp_load) resp_rdata <= rd_oor ? '0 : mem[rd_idx];
      end
   end

`ifdef MEM_RESP_RANGE_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           resp_err <= 1'b0;
      else if (resp_load) resp_err <= rd_oor;
   end
`else
   assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a latency-2 instance driven by vector tables, hand sequences
// and random traffic against a transaction-level model, plus a latency-1 instance.
module tb_mem_responder;
   localparam int DEPTH = 2048;
   localparam int LAT   = 2;
`ifdef MEM_RESP_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
   logic [31:0] req_addr, req_wdata, resp_rdata;
   logic        req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_err1;
   logic [31:0] req_addr1, req_wdata1, resp_rdata1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      int          stall;
      logic [31:0] exp_d;
      bit          exp_e;
   } vec_t;

   vec_t        tbl [11];
   logic [31:0] model [16];

   mem_responder #(.width(32), .depth(DEPTH), .latency(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   mem_responder #(.width(32), .depth(DEPTH), .latency(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
      .req_addr(req_addr1), .req_wdata(req_wdata1),
      .resp_valid(resp_valid1), .resp_ready(resp_ready1),
      .resp_rdata(resp_rdata1), .resp_err(resp_err1)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   // One transaction on the latency-2 instance, starting and ending at a negedge
   task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int stall, input logic [31:0] exp_d, input bit exp_e,
                      input string nm);
      int k;
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
      resp_ready = 1'b0;
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_ready"}, req_ready, 1);
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid = 1'b0;
      if (wr) begin
         chk({nm, "_wr_idle"}, {resp_valid, req_ready}, 2'b01);
         return;
      end
      k = 1;
      while (!resp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_latency"}, k, LAT);
      chk({nm, "_rdata"}, resp_rdata, exp_d);
      chk({nm, "_err"}, resp_err, exp_e);
      for (int s = 0; s < stall; s++) begin
         req_valid = 1'b1; req_write = 1'b1; req_wdata = ~wdata;
         @(negedge clk);
         chk({nm, "_hold_ctl"}, {resp_valid, req_ready, resp_err}, {2'b10, exp_e});
         chk({nm, "_hold_data"}, resp_rdata, exp_d);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_done"}, {resp_valid, req_ready}, 2'b01);
      resp_ready = 1'b0;
   endtask

   initial begin
      int          cyc;
      int          acc[$];
      logic [31:0] got[$];
      bit          seen;
      logic [31:0] a, w, exp_d;
      bit          wr, oor;
      int          idx, stall;

      tbl[0]  = '{1'b1, 32'd5,    32'hDEADBEEF, 0, 32'h0,        1'b0};
      tbl[1]  = '{1'b0, 32'd5,    32'h0,        0, 32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1'b1, 32'd7,    32'h0BADF00D, 0, 32'h0,        1'b0};
      tbl[3]  = '{1'b0, 32'd7,    32'h0,        4, 32'h0BADF00D, 1'b0};
      tbl[4]  = '{1'b0, 32'd7,    32'h0,        0, 32'h0BADF00D, 1'b0};
      tbl[5]  = '{1'b1, 32'd0,    32'hA5A50000, 0, 32'h0,        1'b0};
      tbl[6]  = '{1'b1, 32'd1,    32'h11110001, 0, 32'h0,        1'b0};
      tbl[7]  = '{1'b1, 32'd2048, 32'h12345678, 0, 32'h0,        1'b0};
      tbl[8]  = '{1'b0, 32'd0,    32'h0,        1, RC ? 32'hA5A50000 : 32'h12345678, 1'b0};
      tbl[9]  = '{1'b0, 32'd2048, 32'h0,        2, RC ? 32'h0 : 32'h12345678, RC};
      tbl[10] = '{1'b0, 32'd1,    32'h0,        0, 32'h11110001, 1'b0};

      rst = 1'b0;
      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
      req_valid1 = 0; req_write1 = 0; req_addr1 = 0; req_wdata1 = 0; resp_ready1 = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_outputs", {req_ready, resp_valid, resp_err}, 3'b000);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_ready_l1", req_ready1, 0);
      rst = 1'b1;
      #1;
      chk("release_ready_low", req_ready, 0);
      @(negedge clk);
      chk("release_ready_high", {req_ready, req_ready1}, 2'b11);

      // latency-1 instance: response visible one edge after accept
      req_valid1 = 1; req_write1 = 1; req_addr1 = 3; req_wdata1 = 32'hC0FFEE03;
      @(negedge clk);
      req_valid1 = 1; req_write1 = 0;
      chk("l1_wr_idle", {resp_valid1, req_ready1}, 2'b01);
      @(negedge clk);
      req_valid1 = 0;
      chk("l1_valid_busy", {resp_valid1, req_ready1, resp_err1}, 3'b100);
      chk("l1_rdata", resp_rdata1, 32'hC0FFEE03);
      resp_ready1 = 1;
      @(negedge clk);
      resp_ready1 = 0;
      chk("l1_done", {resp_valid1, req_ready1}, 2'b01);

      for (int i = 0; i < 11; i++)
         txn(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].stall, tbl[i].exp_d,
             tbl[i].exp_e, $sformatf("vec%0d", i));

      // back-to-back reads of 0 and 1 with req_valid and resp_ready held high
      resp_ready = 1; req_valid = 1; req_write = 0; req_addr = 0; cyc = 0;
      while ((acc.size() < 2 || got.size() < 2) && cyc < 30) begin
         if (resp_valid) got.push_back(resp_rdata);
         if (req_valid && req_ready) acc.push_back(cyc);
         @(negedge clk);
         cyc++;
         if (acc.size() >= 1) req_addr = 1;
         if (acc.size() >= 2) req_valid = 0;
      end
      req_valid = 0; resp_ready = 0;
      chk("b2b_counts", {acc.size(), got.size()}, {32'd2, 32'd2});
      if (acc.size() >= 2) chk("b2b_spacing", acc[1] - acc[0], LAT + 1);
      if (got.size() >= 2) begin
         chk("b2b_first", got[0], RC ? 32'hA5A50000 : 32'h12345678);
         chk("b2b_second", got[1], 32'h11110001);
      end

      // reset pulse while a read waits: the read must vanish
      @(negedge clk);
      req_valid = 1; req_write = 0; req_addr = 9;
      chk("rstwait_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 0;
      rst = 1'b0;
      #1;
      chk("rstwait_in_reset", {resp_valid, req_ready}, 2'b00);
      chk("rstwait_rdata", resp_rdata, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstwait_release_low", req_ready, 0);
      @(negedge clk);
      chk("rstwait_ready_back", req_ready, 1);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         if (resp_valid) seen = 1;
         @(negedge clk);
      end
      chk("rstwait_no_resp", seen, 0);

      // random traffic against a word-level model of the memory
      for (int i = 0; i < 16; i++) begin
         model[i] = $urandom;
         txn(1'b1, i, model[i], 0, 0, 1'b0, "init");
      end
      for (int t = 0; t < 150; t++) begin
         a     = $urandom_range(0, 15);
         if ($urandom_range(0, 3) == 0) a = a + DEPTH * $urandom_range(1, 1000);
         wr    = $urandom_range(0, 1);
         w     = $urandom;
         stall = $urandom_range(0, 3);
         idx   = a % DEPTH;
         oor   = RC && (a >= DEPTH);
         if (wr) begin
            if (!oor) model[idx] = w;
            txn(1'b1, a, w, 0, 0, 1'b0, $sformatf("rnd%0d", t));
         end else begin
            exp_d = oor ? 32'h0 : model[idx];
            txn(1'b0, a, w, stall, exp_d, oor, $sformatf("rnd%0d", t));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter: width, 32, data and address bit width.
REQ-002 SHALL have parameter: depth, 2048, number of words in the internal array; power of two.
REQ-003 SHALL have parameter: latency, 2, cycles from read accept to resp_valid; legal range 1..15.
REQ-004 SHALL have port: clk  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port: rst  input  1  one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port: req_valid  input  1  initiator presents a request.
REQ-007 SHALL have port: req_ready  output  1  responder can accept a request this cycle.
REQ-008 SHALL have port: req_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port: req_addr  input  width  word address.
REQ-010 SHALL have port: req_wdata  input  width  write data.
REQ-011 SHALL have port: resp_valid  output  1  read response present.
REQ-012 SHALL have port: resp_ready  input  1  initiator accepts the response.
REQ-013 SHALL have port: resp_rdata  output  width  read data.
REQ-014 SHALL have port: resp_err  output  1  read address out of range (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge where req_valid && req_ready.
REQ-017 SHALL, for an accepted write, update mem[index] at the accept edge, remain in IDLE, produce no response.
REQ-018 SHALL use index = req_addr[log2(depth)-1:0].
REQ-019 SHALL, for an accepted read, register index and go to WAIT with counter = latency-1; if latency = 1, go directly to RESP.
REQ-020 SHALL in WAIT decrement the counter each cycle and enter RESP on the edge where counter = 0.
REQ-021 SHALL load resp_rdata from mem[registered index] on the edge entering RESP; resp_valid rises exactly latency cycles after the accept edge.
REQ-022 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until an edge with resp_ready = 1, then return to IDLE with resp_valid = 0.
REQ-023 SHALL ignore req_valid in WAIT and RESP (req_ready = 0); no request is lost or queued.
REQ-024 SHALL give max read throughput of one read per latency+1 cycles (resp_ready held high).
REQ-025 SHALL treat resp_ready while resp_valid = 0 as no effect.
REQ-026 SHALL keep resp_rdata unchanged outside RESP entry edges.

Reset
REQ-027 SHALL, while rst = 0, force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 0.
REQ-028 SHALL not reset memory array contents.
REQ-029 SHALL, on reset asserted in WAIT or RESP, discard the pending read; no response after rst release.
REQ-030 SHALL assert req_ready on the first rising edge after rst returns to 1.

Configuration
REQ-031 SHALL use macro MEM_RESP_RANGE_CHECK_EN.
REQ-032 SHALL, with macro defined: read with req_addr >= depth sets resp_err = 1 and resp_rdata = 0 in its response; write with req_addr >= depth is accepted and discarded (memory unchanged).
REQ-033 SHALL, without macro: upper address bits ignored (addresses wrap modulo depth), resp_err tied to 0.

Verification
REQ-034 SHALL cover: write addr 5 = 0xDEADBEEF, then read 5, resp_ready=1, latency=2 -> resp_valid 2 cycles after accept, resp_rdata 0xDEADBEEF, resp_err 0.
REQ-035 SHALL cover: read addr 7 with resp_ready=0 for 4 cycles -> resp_valid/resp_rdata held stable, req_ready 0 throughout, IDLE one edge after resp_ready=1.
REQ-036 SHALL cover: back-to-back reads addr 0,1 with req_valid held high -> second accept exactly 3 cycles after first, responses in order.
REQ-037 SHALL cover: rst low for 1 cycle while in WAIT -> resp_valid never rises for that read, req_ready 1 one edge after release.
REQ-038 SHALL cover: write addr 2048 = 0x12345678, read addr 0 -> with macro: memory[0] unchanged, read of 2048 gives resp_err 1, rdata 0; without macro: read addr 0 returns 0x12345678.
REQ-039 SHALL cover: latency=1 build, read addr 3 -> resp_valid on the edge immediately after accept, WAIT never entered.
